// File: rtl/prach_fft_ctrl.sv
// rtl/prach_fft_ctrl.sv - PRACH burst sequencer between a sample stream, an FFT core and the bin stream
// Optional DRAIN watchdog: define PRACH_FFT_CTRL_TIMEOUT_EN
module prach_fft_ctrl #(
  parameter int NUM_FFT_POINTS = 1536,
  parameter int MAX_SYM        = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  num_sym,
  input  logic [15:0] s_dr,
  input  logic [15:0] s_di,
  input  logic        s_dv,
  output logic [15:0] fft_din_dr,
  output logic [15:0] fft_din_di,
  output logic        fft_din_dv,
  output logic        fft_sync_in,
  input  logic [15:0] fft_dout_dr,
  input  logic [15:0] fft_dout_di,
  input  logic        fft_dout_dv,
  input  logic        fft_sync_out,
  output logic [15:0] m_dr,
  output logic [15:0] m_di,
  output logic        m_dv,
  output logic        m_last,
  output logic [10:0] m_idx,
  output logic [3:0]  m_sym,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ARM, FEED, DRAIN} state_t;

  localparam logic [10:0] LAST_IDX  = 11'(NUM_FFT_POINTS - 1);
  localparam logic [3:0]  MAX_SYM_W = 4'(MAX_SYM);

  state_t      state;
  logic [10:0] in_idx;
  logic [3:0]  in_sym;
  logic [3:0]  sym_total;
  logic        first_out;

  logic [3:0]  num_sym_eff;
  logic [10:0] nxt_idx;
  logic [3:0]  nxt_sym;
  logic        sync_err;
  logic        out_fire;
  logic        burst_end;

`ifdef PRACH_FFT_CTRL_TIMEOUT_EN
  logic [11:0] wd_cnt;
`endif

  always_comb begin
    num_sym_eff = num_sym;
    if (num_sym == 4'd0)
      num_sym_eff = 4'd1;
    else if (num_sym > MAX_SYM_W)
      num_sym_eff = MAX_SYM_W;
  end

  // A premature sync restarts the bin index but keeps the symbol number;
  // a natural wrap (with or without sync) advances the symbol.
  always_comb begin
    nxt_idx = m_idx + 11'd1;
    nxt_sym = m_sym;
    if (first_out) begin
      nxt_idx = '0;
      nxt_sym = '0;
    end else if (m_idx == LAST_IDX) begin
      nxt_idx = '0;
      nxt_sym = m_sym + 4'd1;
    end else if (fft_sync_out) begin
      nxt_idx = '0;
    end
    sync_err  = fft_sync_out && !first_out && (m_idx != LAST_IDX);
    out_fire  = fft_dout_dv && ((state == FEED) || (state == DRAIN));
    burst_end = out_fire && (state == DRAIN) && (nxt_idx == LAST_IDX) &&
                (nxt_sym == sym_total - 4'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_idx      <= '0;
      in_sym      <= '0;
      sym_total   <= '0;
      first_out   <= 1'b0;
      fft_din_dr  <= '0;
      fft_din_di  <= '0;
      fft_din_dv  <= 1'b0;
      fft_sync_in <= 1'b0;
      m_dr        <= '0;
      m_di        <= '0;
      m_dv        <= 1'b0;
      m_last      <= 1'b0;
      m_idx       <= '0;
      m_sym       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
`ifdef PRACH_FFT_CTRL_TIMEOUT_EN
      wd_cnt      <= '0;
`endif
    end else if (abort) begin
      state       <= IDLE;
      in_idx      <= '0;
      in_sym      <= '0;
      first_out   <= 1'b0;
      fft_din_dv  <= 1'b0;
      fft_sync_in <= 1'b0;
      m_dv        <= 1'b0;
      m_last      <= 1'b0;
      m_idx       <= '0;
      m_sym       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef PRACH_FFT_CTRL_TIMEOUT_EN
      wd_cnt      <= '0;
`endif
    end else begin
      done        <= 1'b0;
      fft_din_dv  <= 1'b0;
      fft_sync_in <= 1'b0;
      m_dv        <= 1'b0;
      m_last      <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= ARM;
            busy      <= 1'b1;
            err       <= 1'b0;
            sym_total <= num_sym_eff;
            in_idx    <= '0;
            in_sym    <= '0;
            m_idx     <= '0;
            m_sym     <= '0;
            first_out <= 1'b1;
          end
        end
        ARM, FEED: begin
          if (s_dv) begin
            state       <= FEED;
            fft_din_dr  <= s_dr;
            fft_din_di  <= s_di;
            fft_din_dv  <= 1'b1;
            fft_sync_in <= (in_idx == '0);
            if (in_idx == LAST_IDX) begin
              in_idx <= '0;
              in_sym <= in_sym + 4'd1;
              if (in_sym == sym_total - 4'd1)
                state <= DRAIN;
            end else begin
              in_idx <= in_idx + 11'd1;
            end
          end
        end
        default: ;
      endcase

      if (out_fire) begin
        m_dr      <= fft_dout_dr;
        m_di      <= fft_dout_di;
        m_dv      <= 1'b1;
        m_idx     <= nxt_idx;
        m_sym     <= nxt_sym;
        m_last    <= (nxt_idx == LAST_IDX);
        first_out <= 1'b0;
        if (sync_err)
          err <= 1'b1;
        if (burst_end) begin
          done  <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
      end

`ifdef PRACH_FFT_CTRL_TIMEOUT_EN
      // Fires on the 4095th consecutive DRAIN cycle without FFT output.
      if ((state != DRAIN) || fft_dout_dv) begin
        wd_cnt <= '0;
      end else if (wd_cnt == 12'd4094) begin
        wd_cnt <= '0;
        err    <= 1'b1;
        state  <= IDLE;
        busy   <= 1'b0;
      end else begin
        wd_cnt <= wd_cnt + 12'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_prach_fft_ctrl.sv
// tb/tb_prach_fft_ctrl.sv - randomized self-checking bench for prach_fft_ctrl with a delay-line FFT model
module tb_prach_fft_ctrl;
  localparam int N    = 1536;
  localparam int MAXS = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  num_sym = '0;
  logic [15:0] s_dr = '0;
  logic [15:0] s_di = '0;
  logic        s_dv = 1'b0;
  logic [15:0] fft_din_dr, fft_din_di;
  logic        fft_din_dv, fft_sync_in;
  logic [15:0] fft_dout_dr = '0;
  logic [15:0] fft_dout_di = '0;
  logic        fft_dout_dv = 1'b0;
  logic        fft_sync_out = 1'b0;
  logic [15:0] m_dr, m_di;
  logic        m_dv, m_last;
  logic [10:0] m_idx;
  logic [3:0]  m_sym;
  logic        busy, done, err;

  prach_fft_ctrl #(.NUM_FFT_POINTS(N), .MAX_SYM(MAXS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_sym(num_sym),
    .s_dr(s_dr), .s_di(s_di), .s_dv(s_dv),
    .fft_din_dr(fft_din_dr), .fft_din_di(fft_din_di), .fft_din_dv(fft_din_dv), .fft_sync_in(fft_sync_in),
    .fft_dout_dr(fft_dout_dr), .fft_dout_di(fft_dout_di), .fft_dout_dv(fft_dout_dv), .fft_sync_out(fft_sync_out),
    .m_dr(m_dr), .m_di(m_di), .m_dv(m_dv), .m_last(m_last), .m_idx(m_idx), .m_sym(m_sym),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] dr; logic [15:0] di; logic [10:0] idx; logic [3:0] sym; logic last; logic dn; } mrec_t;
  typedef struct { logic [15:0] dr; logic [15:0] di; logic sync; longint t; } drec_t;
  typedef struct { logic [15:0] dr; logic [15:0] di; longint t; } srec_t;
  typedef struct { int due; logic [15:0] dr; logic [15:0] di; logic sync; } frec_t;

  int total = 0;
  int bad = 0;
  mrec_t m_log[$];
  drec_t din_log[$];
  srec_t sent[$];
  frec_t fq[$];
  int done_cnt = 0;
  int cyc = 0;
  int lat = 20;
  int inject_at = -1;
  int stop_after = -1;
  int emitted = 0;

  // Output logger plus an identity "FFT": each accepted input returns lat cycles later.
  initial begin
    frec_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (m_dv) m_log.push_back('{m_dr, m_di, m_idx, m_sym, m_last, done});
      if (done) done_cnt++;
      if (fft_din_dv) begin
        din_log.push_back('{fft_din_dr, fft_din_di, fft_sync_in, $time});
        fq.push_back('{cyc + lat, fft_din_dr, fft_din_di, fft_sync_in});
      end
      fft_dout_dv = 1'b0;
      fft_sync_out = 1'b0;
      if (fq.size() > 0 && fq[0].due <= cyc) begin
        e = fq.pop_front();
        if (stop_after < 0 || emitted < stop_after) begin
          fft_dout_dr = e.dr;
          fft_dout_di = e.di;
          fft_dout_dv = 1'b1;
          fft_sync_out = e.sync || (emitted == inject_at);
        end
        emitted++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  function automatic int ref_bin_errors(input int nexp);
    int e = 0;
    if (m_log.size() != nexp) e++;
    for (int i = 0; i < nexp && i < m_log.size() && i < sent.size(); i++) begin
      if (m_log[i].dr !== sent[i].dr || m_log[i].di !== sent[i].di) e++;
      if (m_log[i].idx !== 11'(i % N)) e++;
      if (m_log[i].sym !== 4'(i / N)) e++;
      if (m_log[i].last !== ((i % N) == N - 1)) e++;
      if (m_log[i].dn !== (i == nexp - 1)) e++;
    end
    return e;
  endfunction

  function automatic int ref_din_errors(input int nexp);
    int e = 0;
    if (din_log.size() != nexp) e++;
    for (int i = 0; i < nexp && i < din_log.size() && i < sent.size(); i++) begin
      if (din_log[i].dr !== sent[i].dr || din_log[i].di !== sent[i].di) e++;
      if (din_log[i].t != sent[i].t + 10) e++;
      if (din_log[i].sync !== ((i % N) == 0)) e++;
    end
    return e;
  endfunction

  task automatic clear_logs();
    @(posedge clk); #1;
    m_log.delete(); din_log.delete(); sent.delete(); fq.delete();
    done_cnt = 0; emitted = 0;
  endtask

  task automatic drive_start(input logic [3:0] n);
    @(negedge clk); start = 1'b1; num_sym = n;
    @(negedge clk); start = 1'b0; num_sym = 4'($urandom_range(0, 15));
  endtask

  task automatic send(input int count, input int gap);
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      s_dv = 1'b1; s_dr = 16'($urandom); s_di = 16'($urandom);
      sent.push_back('{s_dr, s_di, $time});
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); s_dv = 1'b0;
      end
    end
    @(negedge clk); s_dv = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    total++; if (err !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_status: err=%0b done=%0b expected 0 0", err, done); end
    total++; if (fft_din_dv !== 1'b0 || fft_sync_in !== 1'b0 || fft_din_dr !== 16'h0) begin bad++; $display("FAIL reset_din: dv=%0b sync=%0b dr=%0h expected 0", fft_din_dv, fft_sync_in, fft_din_dr); end
    total++; if (m_dv !== 1'b0 || m_last !== 1'b0 || m_idx !== 11'd0 || m_sym !== 4'd0 || m_dr !== 16'h0) begin bad++; $display("FAIL reset_m: dv=%0b last=%0b idx=%0d sym=%0d expected 0", m_dv, m_last, m_idx, m_sym); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_two_symbols();
    bit ok;
    int ns, badpos, nlast;
    clear_logs(); lat = 1582;
    drive_start(4'd2);
    send(2 * N + 8, 0);
    wait_idle(3000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL two_sym_idle: busy still %0b expected 0", busy); end
    ns = 0; badpos = 0;
    foreach (din_log[i]) if (din_log[i].sync) begin ns++; if (i != 0 && i != N) badpos++; end
    total++; if (ns != 2 || badpos != 0) begin bad++; $display("FAIL two_sym_sync_in: count=%0d misplaced=%0d expected 2 0", ns, badpos); end
    total++; if (ref_din_errors(2 * N) != 0) begin bad++; $display("FAIL two_sym_din: errors=%0d expected 0", ref_din_errors(2 * N)); end
    total++; if (ref_bin_errors(2 * N) != 0) begin bad++; $display("FAIL two_sym_bins: errors=%0d got %0d bins expected %0d", ref_bin_errors(2 * N), m_log.size(), 2 * N); end
    nlast = 0;
    foreach (m_log[i]) if (m_log[i].last) nlast++;
    total++; if (nlast != 2) begin bad++; $display("FAIL two_sym_last: got %0d expected 2", nlast); end
    total++; if (done_cnt != 1 || err !== 1'b0) begin bad++; $display("FAIL two_sym_done_err: done=%0d err=%0b expected 1 0", done_cnt, err); end
  endtask

  task automatic test_gapped();
    bit ok;
    clear_logs(); lat = 20;
    drive_start(4'd1);
    send(N, 1);
    wait_idle(200, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL gapped_idle: busy still %0b expected 0", busy); end
    total++; if (ref_din_errors(N) != 0) begin bad++; $display("FAIL gapped_din: errors=%0d expected 0", ref_din_errors(N)); end
    total++; if (ref_bin_errors(N) != 0) begin bad++; $display("FAIL gapped_bins: errors=%0d expected 0", ref_bin_errors(N)); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL gapped_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_extra_sync();
    clear_logs(); lat = 20; inject_at = 700;
    drive_start(4'd1);
    send(N, 0);
    repeat (40) @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL xsync_err: got %0b expected 1", err); end
    total++; if (m_log.size() != N) begin bad++; $display("FAIL xsync_count: got %0d expected %0d", m_log.size(), N); end
    if (m_log.size() == N) begin
      total++; if (m_log[699].idx !== 11'd699 || m_log[700].idx !== 11'd0 || m_log[701].idx !== 11'd1) begin
        bad++; $display("FAIL xsync_restart: idx %0d %0d %0d expected 699 0 1", m_log[699].idx, m_log[700].idx, m_log[701].idx); end
      total++; if (m_log[N-1].idx !== 11'(N - 1 - 700)) begin bad++; $display("FAIL xsync_tail: got %0d expected %0d", m_log[N-1].idx, N - 1 - 700); end
    end
    total++; if (busy !== 1'b1 || done_cnt != 0) begin bad++; $display("FAIL xsync_continue: busy=%0b done=%0d expected 1 0", busy, done_cnt); end
    inject_at = -1;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    total++; if (busy !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL xsync_abort: busy=%0b err=%0b expected 0 1", busy, err); end
    drive_start(4'd1);
    total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL xsync_restart_clears: err=%0b busy=%0b expected 0 1", err, busy); end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  task automatic test_abort();
    bit ok;
    int n0;
    clear_logs(); lat = 20;
    drive_start(4'd2);
    send(500, 0);
    @(negedge clk); s_dv = 1'b1; s_dr = 16'($urandom); s_di = 16'($urandom); abort = 1'b1; start = 1'b1; num_sym = 4'd1;
    @(negedge clk); s_dv = 1'b0; abort = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0 || fft_din_dv !== 1'b0) begin bad++; $display("FAIL abort_next: busy=%0b din_dv=%0b expected 0 0", busy, fft_din_dv); end
    total++; if (m_idx !== 11'd0 || m_sym !== 4'd0 || m_dv !== 1'b0) begin bad++; $display("FAIL abort_clear: idx=%0d sym=%0d dv=%0b expected 0", m_idx, m_sym, m_dv); end
    n0 = m_log.size();
    repeat (60) @(negedge clk);
    total++; if (m_log.size() != n0 || done_cnt != 0) begin bad++; $display("FAIL abort_discard: bins %0d->%0d done=%0d expected no change 0", n0, m_log.size(), done_cnt); end
    clear_logs();
    drive_start(4'd1);
    send(N, 0);
    wait_idle(200, ok);
    total++; if (ok !== 1'b1 || ref_bin_errors(N) != 0 || done_cnt != 1) begin
      bad++; $display("FAIL abort_new_burst: idle=%0b errors=%0d done=%0d expected 1 0 1", ok, ref_bin_errors(N), done_cnt); end
  endtask

  task automatic test_busy_start();
    bit ok;
    clear_logs(); lat = 20;
    drive_start(4'd0);
    drive_start(4'd2);
    send(N + 100, 0);
    wait_idle(200, ok);
    total++; if (din_log.size() != N) begin bad++; $display("FAIL busy_start_din: got %0d expected %0d", din_log.size(), N); end
    total++; if (ref_bin_errors(N) != 0) begin bad++; $display("FAIL busy_start_bins: errors=%0d got %0d bins expected %0d", ref_bin_errors(N), m_log.size(), N); end
    total++; if (done_cnt != 1 || ok !== 1'b1) begin bad++; $display("FAIL busy_start_done: done=%0d idle=%0b expected 1 1", done_cnt, ok); end
  endtask

  task automatic test_clamp();
    bit ok;
    clear_logs(); lat = 20;
    drive_start(4'd15);
    send(MAXS * N + 20, 0);
    wait_idle(200, ok);
    total++; if (din_log.size() != MAXS * N) begin bad++; $display("FAIL clamp_din: got %0d expected %0d", din_log.size(), MAXS * N); end
    total++; if (ref_bin_errors(MAXS * N) != 0 || done_cnt != 1) begin bad++; $display("FAIL clamp_bins: errors=%0d done=%0d expected 0 1", ref_bin_errors(MAXS * N), done_cnt); end
  endtask

  task automatic test_reset_mid();
    int n0;
    clear_logs(); lat = 20;
    drive_start(4'd1);
    send(300, 0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    total++; if (busy !== 1'b0 || fft_din_dv !== 1'b0 || m_dv !== 1'b0) begin bad++; $display("FAIL reset_mid: busy=%0b din_dv=%0b m_dv=%0b expected 0", busy, fft_din_dv, m_dv); end
    n0 = m_log.size();
    repeat (60) @(negedge clk);
    total++; if (done_cnt != 0 || m_log.size() != n0) begin bad++; $display("FAIL reset_mid_quiet: done=%0d bins %0d->%0d expected 0 no change", done_cnt, n0, m_log.size()); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs(); lat = 20; stop_after = 100;
    drive_start(4'd1);
    send(N, 0);
    repeat (3990) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL timeout_early: busy=%0b expected 1", busy); end
`ifdef PRACH_FFT_CTRL_TIMEOUT_EN
    wait_idle(300, ok);
    total++; if (ok !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL timeout_fire: idle=%0b err=%0b expected 1 1", ok, err); end
    total++; if (done_cnt != 0 || m_log.size() != 100) begin bad++; $display("FAIL timeout_nodone: done=%0d bins=%0d expected 0 100", done_cnt, m_log.size()); end
`else
    wait_idle(1000, ok);
    total++; if (ok !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL no_timeout: idle=%0b busy=%0b err=%0b expected 0 1 0", ok, busy, err); end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
`endif
    stop_after = -1;
  endtask

  initial begin
    test_reset();
    test_two_symbols();
    test_gapped();
    test_extra_sync();
    test_abort();
    test_busy_start();
    test_clamp();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prach_fft_ctrl.md
PRACH_FFT_CTRL -- requirements
Module: prach_fft_ctrl

Interface
REQ-001 SHALL have parameter NUM_FFT_POINTS, default 1536, meaning samples per PRACH symbol (3*2^9 FFT).
REQ-002 SHALL have parameter MAX_SYM, default 14, meaning the largest symbols-per-burst value accepted.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1, reset; one clock, synchronous, active-low.
REQ-005 SHALL have ports start/abort, input, 1 each, burst request and burst cancel pulses.
REQ-006 SHALL have port num_sym, input, 4, symbols per burst, sampled on an accepted start.
REQ-007 SHALL have ports s_dr/s_di, input, 16 each, plus s_dv, input, 1, upstream time-domain samples.
REQ-008 SHALL have ports fft_din_dr/fft_din_di, output, 16 each, plus fft_din_dv/fft_sync_in, output, 1 each, driving the FFT.
REQ-009 SHALL have ports fft_dout_dr/fft_dout_di, input, 16 each, plus fft_dout_dv/fft_sync_out, input, 1 each, from the FFT.
REQ-010 SHALL have ports m_dr/m_di, output, 16 each; m_dv, m_last, output, 1 each; m_idx, output, 11; m_sym, output, 4: downstream bins.
REQ-011 SHALL have ports busy, done, err, output, 1 each, status.

Function
REQ-012 SHALL implement states IDLE, ARM, FEED, DRAIN.
REQ-013 IDLE: start with busy=0 latches num_sym and moves to ARM; num_sym=0 is treated as 1; num_sym>MAX_SYM is clamped to MAX_SYM.
REQ-014 start while busy=1 SHALL be ignored.
REQ-015 ARM -> FEED on the first s_dv=1; that sample is input index 0 of symbol 0.
REQ-016 FEED: every s_dv=1 sample is forwarded to fft_din_* with exactly 1-cycle registered latency; fft_din_dv=0 when s_dv=0.
REQ-017 fft_sync_in SHALL pulse with fft_din_dv on input index 0 of every symbol.
REQ-018 Input index counts 0..NUM_FFT_POINTS-1 on s_dv and wraps to 0, incrementing the input symbol count.
REQ-019 After the last sample of symbol num_sym-1, the state moves to DRAIN; further s_dv is not forwarded.
REQ-020 Output side, in FEED and DRAIN: fft_sync_out with fft_dout_dv resets m_idx to 0; each further fft_dout_dv increments m_idx.
REQ-021 m_* SHALL be the FFT output registered 1 cycle, with m_dv=fft_dout_dv in FEED/DRAIN and 0 otherwise.
REQ-022 m_sym SHALL be the output symbol number; m_last=1 on m_idx=NUM_FFT_POINTS-1.
REQ-023 DRAIN -> IDLE after the m_last of symbol num_sym-1, with done pulsing 1 cycle coincident with that m_last.
REQ-024 fft_sync_out arriving when m_idx is not NUM_FFT_POINTS-1 (except the first output of a burst) SHALL set err; the burst continues.
REQ-025 fft_dout_dv in IDLE/ARM SHALL be discarded.
REQ-026 busy=1 in ARM, FEED and DRAIN.
REQ-027 abort SHALL take effect in any state, overriding a start in the same cycle: next cycle state=IDLE, fft_din_dv=0, counters cleared, no done.
REQ-028 err is sticky and clears only on an accepted start or on reset.

Reset
REQ-029 While rst_n=0 at a clk edge: state=IDLE; all counters 0; fft_din_*, fft_sync_in, m_*, busy, done and err all 0.
REQ-030 Reset asserted mid-burst SHALL abandon the burst with no done pulse.

Configuration
REQ-031 With PRACH_FFT_CTRL_TIMEOUT_EN defined, a 12-bit watchdog in DRAIN counts cycles since the last fft_dout_dv.
- Count reaching 4095 sets err, forces IDLE and gives no done.
REQ-032 Without PRACH_FFT_CTRL_TIMEOUT_EN, no watchdog logic exists and DRAIN waits indefinitely.

Verification
REQ-033 Reset then start with num_sym=2 and 3072 contiguous s_dv, FFT model latency 1582:
- fft_sync_in pulses at input samples 0 and 1536.
- 3072 m_dv are seen, m_last twice, done once, err=0.
REQ-034 num_sym=1 with s_dv gapped 1-on/1-off:
- fft_din_dv mirrors the gaps with 1-cycle delay.
- m_idx runs 0..1535 and done fires.
REQ-035 FFT model emits an extra fft_sync_out at m_idx=700:
- err=1 and m_idx restarts at 0.
- A following start clears err.
REQ-036 abort at input sample 500 of symbol 0:
- Next cycle busy=0 and fft_din_dv=0.
- No done; a new start is then accepted.
REQ-037 With PRACH_FFT_CTRL_TIMEOUT_EN, the FFT model stops output after 100 bins:
- err=1 and busy=0 after 4095 idle cycles.
- Without the macro, busy stays 1.
REQ-038 start while busy, and num_sym=0:
- The start while busy is ignored.
- num_sym=0 produces exactly 1536 m_dv then done.
